affine_addr_gen_nd: RTL and testbench

- Parametrised N-dimensional affine address generator; successor to the fixed 2-D x/y scan address path.
- Walks a nested loop nest of up to NDIM dimensions, with dimension 0 innermost.
- Emits offset + accumulated strides one address per accepted handshake; adds start/done control and valid/ready backpressure.
- Feeds memory read/write ports of the op datapath.

---
 rtl/affine_addr_gen_nd.sv | 101 ++++++++++
 tb/tb_affine_addr_gen_nd.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/affine_addr_gen_nd.sv
// affine_addr_gen_nd: N-dimensional affine address walker with start/done control and valid/ready output.
module affine_addr_gen_nd #(
  parameter int DATA_W = 32,
  parameter int NDIM   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(NDIM+1)-1:0]  num_dims,
  input  logic [DATA_W-1:0]          offset,
  input  logic [NDIM*CNT_W-1:0]      extent,
  input  logic [NDIM*DATA_W-1:0]     stride,
  output logic [DATA_W-1:0]          addr,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic                       addr_last,
  output logic                       busy,
  output logic                       done
);
  localparam int ND_W = $clog2(NDIM+1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q;
  logic [DATA_W-1:0] off_q, acc_q, acc_d, step, addr_q;
  logic [DATA_W-1:0] str_q [NDIM];
  logic [CNT_W-1:0] ext_q [NDIM];
  logic [CNT_W-1:0] cnt_q [NDIM];
  logic [CNT_W-1:0] cnt_d [NDIM];
  logic [CNT_W-1:0] ext_in [NDIM];
  logic [NDIM-1:0] at_max;
  logic [ND_W-1:0] nd_eff;
  logic empty, single, carry, last_d, valid_q, last_q, done_q, fire;
  assign addr = addr_q;
  assign addr_valid = valid_q;
  assign addr_last = last_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign fire = valid_q & addr_ready;
  // Odometer step: the lowest dim not at its top advances, all dims below it wrap to 0.
  always_comb begin
    nd_eff = num_dims == '0 ? ND_W'(1) : num_dims > ND_W'(NDIM) ? ND_W'(NDIM) : num_dims;
    empty = 1'b0;
    single = 1'b1;
    carry = 1'b1;
    last_d = 1'b1;
    step = '0;
    for (int d = 0; d < NDIM; d++) begin
      ext_in[d] = ND_W'(d) < nd_eff ? extent[d*CNT_W +: CNT_W] : CNT_W'(1);
      empty |= ext_in[d] == '0;
      single &= ext_in[d] == CNT_W'(1);
      at_max[d] = cnt_q[d] == ext_q[d] - CNT_W'(1);
      cnt_d[d] = !carry ? cnt_q[d] : at_max[d] ? '0 : cnt_q[d] + CNT_W'(1);
      step = carry && !at_max[d] ? str_q[d] : step;
      carry &= at_max[d];
      last_d &= cnt_d[d] == ext_q[d] - CNT_W'(1);
    end
    acc_d = acc_q + step;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q <= '0;
      acc_q <= '0;
      addr_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      for (int d = 0; d < NDIM; d++) begin
        ext_q[d] <= '0;
        str_q[d] <= '0;
        cnt_q[d] <= '0;
      end
    end else begin
      done_q <= state_q == FLUSH || (fire && last_q);
      if (state_q == IDLE && start) begin
        state_q <= empty ? FLUSH : RUN;
        valid_q <= !empty;
        last_q <= single;
        off_q <= offset;
        addr_q <= offset;
        acc_q <= '0;
        for (int d = 0; d < NDIM; d++) begin
          ext_q[d] <= ext_in[d];
          str_q[d] <= stride[d*DATA_W +: DATA_W];
          cnt_q[d] <= '0;
        end
      end else if (state_q == FLUSH) begin
        state_q <= IDLE;
      end else if (fire && last_q) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        last_q <= 1'b0;
      end else if (fire) begin
        acc_q <= acc_d;
        addr_q <= off_q + acc_d;
        last_q <= last_d;
        for (int d = 0; d < NDIM; d++) cnt_q[d] <= cnt_d[d];
      end
    end
  end
endmodule

// File: tb/tb_affine_addr_gen_nd.sv
// tb_affine_addr_gen_nd: scoreboard bench with a closed-form address model for the 4-D walker.
module tb_affine_addr_gen_nd;
  logic clk, rst, start, addr_ready, addr_valid, addr_last, busy, done;
  logic [2:0] num_dims;
  logic [31:0] offset, addr;
  logic [63:0] extent, r_ext;
  logic [127:0] stride, r_str;
  int checks = 0, errors = 0, hs_cnt = 0, mode = 0, rc = 0;
  typedef struct {logic [31:0] a; bit l;} exp_t;
  exp_t exp_q[$];

  affine_addr_gen_nd #(.DATA_W(32), .NDIM(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_dims(num_dims), .offset(offset),
    .extent(extent), .stride(stride), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .addr_last(addr_last), .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    addr_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      addr_ready = mode == 0 ? 1'b1 : mode == 1 ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bit stall = 0, last_hs = 0;
    logic [31:0] hold_a;
    logic hold_l;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        last_hs = 0;
      end else begin
        chk("busy_eq_valid", busy, addr_valid);
        if (stall) begin
          chk("hold_valid", addr_valid, 1);
          chk("hold_addr", addr, hold_a);
          chk("hold_last", addr_last, hold_l);
        end
        if (last_hs) begin
          chk("done_after_last", done, 1);
          chk("valid_after_last", addr_valid, 0);
        end
        last_hs = 0;
        if (addr_valid && addr_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("unexpected_addr", {32'd1, addr}, 0);
          else begin
            e = exp_q.pop_front();
            chk("addr", addr, e.a);
            chk("last", addr_last, 64'(e.l));
            last_hs = e.l;
          end
        end
        stall = addr_valid && !addr_ready;
        hold_a = addr;
        hold_l = addr_last;
      end
    end
  end

  // Address at linear index i: dim k has advanced floor(i/P_k) - floor(i/P_{k+1}) times, P_k = product of lower extents.
  task automatic walk(input int nd, input logic [31:0] off, input logic [63:0] ext,
                      input logic [127:0] str, input bit poke, input int rst_after);
    int ne, n, hs0;
    int e[4];
    longint p[5];
    logic [31:0] a;
    bit got;
    ne = nd == 0 ? 1 : nd > 4 ? 4 : nd;
    p[0] = 1;
    for (int d = 0; d < 4; d++) begin
      e[d] = d < ne ? int'(ext[d*16 +: 16]) : 1;
      p[d+1] = p[d] * e[d];
    end
    for (longint i = 0; i < p[4]; i++) begin
      a = off;
      for (int d = 0; d < 4; d++) a += 32'((i / p[d] - i / p[d+1]) * longint'(str[d*32 +: 32]));
      exp_q.push_back('{a, i == p[4] - 1});
    end
    num_dims = 3'(nd);
    offset = off;
    extent = ext;
    stride = str;
    start = 1;
    hs0 = hs_cnt;
    n = 0;
    got = 0;
    while (n < 2000 && !got) begin
      @(negedge clk);
      #1;
      n++;
      start = poke && n == 3;
      if (n == 1) begin
        offset = $urandom;
        extent = {$urandom, $urandom};
        stride = {$urandom, $urandom, $urandom, $urandom};
        num_dims = 3'($urandom);
      end
      if (rst_after > 0 && hs_cnt - hs0 >= rst_after) begin
        rst = 1;
        start = 1;
        @(negedge clk);
        #1;
        rst = 0;
        start = 0;
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        #1;
        chk("rst_start_ignored", addr_valid, 0);
        chk("rst_no_done", done, 0);
        exp_q.delete();
        return;
      end
      if (done) got = 1;
    end
    start = 0;
    if (!got) chk("walk_timeout", 0, 1);
    else if (p[4] == 0) chk("empty_done_latency", n, 2);
    else if (mode == 0) chk("walk_cycles", n, p[4] + 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1;
    start = 1;
    num_dims = 2;
    offset = 32'h1234;
    extent = {16'd1, 16'd1, 16'd3, 16'd4};
    stride = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", addr, 0);
    chk("reset_valid", addr_valid, 0);
    chk("reset_last", addr_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #1;
    rst = 0;
    start = 0;
    repeat (2) @(negedge clk);
    chk("start_with_rst_ignored", addr_valid, 0);
    #1;
    mode = 0;
    walk(2, 100, {16'd1, 16'd1, 16'd3, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 0, 0);
    mode = 1;
    walk(2, 100, {16'd1, 16'd1, 16'd3, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 0, 0);
    mode = 0;
    walk(3, 0, {16'd1, 16'd2, 16'd2, 16'd2}, {32'd99, 32'd10, 32'd3, 32'd1}, 0, 0);
    walk(5, 0, {16'd1, 16'd2, 16'd2, 16'd2}, {32'd99, 32'd10, 32'd3, 32'd1}, 0, 0);
    walk(2, 7, {16'd1, 16'd1, 16'd0, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 0, 0);
    walk(4, 55, {16'd1, 16'd1, 16'd1, 16'd1}, {32'd5, 32'd5, 32'd5, 32'd5}, 0, 0);
    walk(0, 9, {16'd3, 16'd3, 16'd3, 16'd2}, {32'd5, 32'd5, 32'd5, 32'd4}, 0, 0);
    walk(1, 32'hFFFF_FFFE, {16'd9, 16'd9, 16'd9, 16'd4}, {32'd5, 32'd5, 32'd5, 32'd1}, 0, 0);
    walk(2, 100, {16'd1, 16'd1, 16'd3, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 1, 0);
    walk(2, 100, {16'd1, 16'd1, 16'd3, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 0, 5);
    walk(2, 100, {16'd1, 16'd1, 16'd3, 16'd4}, {32'd0, 32'd0, 32'd7, 32'd1}, 0, 0);
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      for (int d = 0; d < 4; d++) begin
        r_ext[d*16 +: 16] = $urandom_range(0, 11) == 0 ? 16'd0 : 16'($urandom_range(1, 4));
        r_str[d*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      walk($urandom_range(0, 7), $urandom, r_ext, r_str, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
